// File: rtl/i2c_pkg.sv
// Shared types and constants for the codec-side I2C responder.
// Holds the responder state encoding and the codec frame geometry.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ACK,
    IGNORE
  } i2c_rsp_state_t;

  localparam logic [6:0] CODEC_DEV_ADDR  = 7'b0011010;
  localparam int         I2C_FRAME_BYTES = 3;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with edge, START and STOP detection.
// Flops reset to the idle bus level so release from reset is quiet.
module i2c_bus_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_sync,
  output logic start_det,
  output logic stop_det
);

  logic [STAGES-1:0] scl_q;
  logic [STAGES-1:0] sda_q;
  logic              scl_d;
  logic              sda_d;
  logic              scl_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_q <= {scl_q[STAGES-2:0], scl};
      sda_q <= {sda_q[STAGES-2:0], sda};
      scl_d <= scl_q[STAGES-1];
      sda_d <= sda_q[STAGES-1];
    end
  end

  assign scl_s     = scl_q[STAGES-1];
  assign sda_sync  = sda_q[STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_sync;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_sync;

endmodule

// File: rtl/i2c_codec_responder.sv
// I2C target modelling the codec's 3-byte write-only control port.
// Acks matching frames and strobes each 7-bit addr / 9-bit data write.
module i2c_codec_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = CODEC_DEV_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sclk,
  input  logic       i_sdat,
  output logic       o_sdat_oen,
  output logic [6:0] o_reg_addr,
  output logic [8:0] o_reg_data,
  output logic       o_wr_valid,
  output logic       o_busy,
  output logic       o_nack
);

  localparam logic [1:0] LAST = 2'(I2C_FRAME_BYTES - 1);

  logic scl_rise, scl_fall, sda_sync;
  logic start_det, stop_det;

  i2c_bus_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .scl      (i_sclk),
    .sda      (i_sdat),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_sync (sda_sync),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  i2c_rsp_state_t state, state_n;
  logic [2:0] bit_cnt, bit_n;
  logic [1:0] byte_cnt, byte_n;
  logic [7:0] shreg, sh_n;
  logic       full, full_n;
  logic [6:0] addr_tmp, addr_tmp_n;
  logic       d8, d8_n;
  logic       oen_n, busy_n, wr_n, nack_n;
  logic [6:0] raddr_n;
  logic [8:0] rdata_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      shreg      <= '0;
      full       <= 1'b0;
      addr_tmp   <= '0;
      d8         <= 1'b0;
      o_sdat_oen <= 1'b0;
      o_busy     <= 1'b0;
      o_wr_valid <= 1'b0;
      o_nack     <= 1'b0;
      o_reg_addr <= '0;
      o_reg_data <= '0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_n;
      byte_cnt   <= byte_n;
      shreg      <= sh_n;
      full       <= full_n;
      addr_tmp   <= addr_tmp_n;
      d8         <= d8_n;
      o_sdat_oen <= oen_n;
      o_busy     <= busy_n;
      o_wr_valid <= wr_n;
      o_nack     <= nack_n;
      o_reg_addr <= raddr_n;
      o_reg_data <= rdata_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_n      = bit_cnt;
    byte_n     = byte_cnt;
    sh_n       = shreg;
    full_n     = full;
    addr_tmp_n = addr_tmp;
    d8_n       = d8;
    oen_n      = o_sdat_oen;
    busy_n     = o_busy;
    wr_n       = 1'b0;
    nack_n     = 1'b0;
    raddr_n    = o_reg_addr;
    rdata_n    = o_reg_data;
    if (start_det) begin
      state_n = SHIFT;
      bit_n   = '0;
      byte_n  = '0;
      full_n  = 1'b0;
      oen_n   = 1'b0;
      busy_n  = 1'b1;
    end else if (stop_det) begin
      state_n = IDLE;
      full_n  = 1'b0;
      oen_n   = 1'b0;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        SHIFT: begin
          if (scl_rise && !full) begin
            sh_n   = {shreg[6:0], sda_sync};
            bit_n  = bit_cnt + 3'd1;
            full_n = (bit_cnt == 3'd7);
          end else if (scl_fall && full) begin
            // full byte is in shreg; decide on this falling edge
            full_n = 1'b0;
            bit_n  = '0;
            if (byte_cnt == 2'd0) begin
              if (shreg == {DEV_ADDR, 1'b0}) begin
                state_n = ACK;
                oen_n   = 1'b1;
              end else begin
                state_n = IGNORE;
                nack_n  = 1'b1;
              end
            end else begin
              if (byte_cnt == 2'd1) begin
                addr_tmp_n = shreg[7:1];
                d8_n       = shreg[0];
              end
              state_n = ACK;
              oen_n   = 1'b1;
            end
          end
        end
        ACK: begin
          if (scl_fall) begin
            oen_n  = 1'b0;
            byte_n = byte_cnt + 2'd1;
            bit_n  = '0;
            if (byte_cnt == LAST) begin
              raddr_n = addr_tmp;
              rdata_n = {d8, shreg};
              wr_n    = 1'b1;
              state_n = IGNORE;
            end else begin
              state_n = SHIFT;
            end
          end
        end
        IDLE:   ;
        IGNORE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench: bit-banged I2C initiator, frame-level model and write scoreboard.
// Expected writes are queued at stimulus time and popped by a monitor.
module tb_i2c_codec_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       oen;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       wr_valid, busy, nack;

  assign sda_bus = sda_m & ~oen;

  i2c_codec_responder dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_sclk    (scl_m),
    .i_sdat    (sda_bus),
    .o_sdat_oen(oen),
    .o_reg_addr(reg_addr),
    .o_reg_data(reg_data),
    .o_wr_valid(wr_valid),
    .o_busy    (busy),
    .o_nack    (nack)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int nack_seen = 0;
  int nack_exp = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  fb[4];
  int          last_addr = 0;
  int          last_data = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (nack) nack_seen++;
      if (wr_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL wr_unexpected: got %0h/%0h expected none",
                   reg_addr, reg_data);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if ({reg_addr, reg_data} !== e) begin
            errs++;
            $display("FAIL wr_data: got %0h/%0h expected %0h/%0h",
                     reg_addr, reg_data, e[15:9], e[8:0]);
          end
        end
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; clks(4);
    scl_m = 1'b1; clks(4);
    sda_m = 1'b0; clks(4);
    scl_m = 1'b0; clks(4);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; clks(4);
    scl_m = 1'b1; clks(4);
    sda_m = 1'b1; clks(8);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; clks(4);
      scl_m = 1'b1; clks(8);
      scl_m = 1'b0; clks(4);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_ack,
                           input bit do_rst);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; clks(4);
      scl_m = 1'b1;
      if (i == 7) begin
        clks(4);
        chk("oen_released", 32'(oen), 32'd0);
        clks(4);
      end else begin
        clks(8);
      end
      scl_m = 1'b0; clks(4);
    end
    sda_m = 1'b1; clks(4);
    scl_m = 1'b1; clks(4);
    chk("ack", 32'(sda_bus), 32'(!exp_ack));
    if (do_rst) begin
      rst_n = 1'b0;
      #1;
      chk("rst_async_oen", 32'(oen), 32'd0);
    end
    clks(4);
    scl_m = 1'b0; clks(4);
  endtask

  task automatic run_frame(input int n, input bit stop);
    bit ok;
    i2c_start;
    clks(2);
    chk("busy_in_frame", 32'(busy), 32'd1);
    ok = (fb[0] == 8'h34);
    if (!ok) nack_exp++;
    if (ok && n >= 3) begin
      last_addr = int'(fb[1]) / 2;
      last_data = (int'(fb[1]) % 2) * 256 + int'(fb[2]);
      exp_q.push_back({7'(last_addr), 9'(last_data)});
    end
    for (int i = 0; i < n; i++) send_byte(fb[i], ok && i < 3, 1'b0);
    if (stop) begin
      i2c_stop;
      clks(4);
      chk("busy_after_stop", 32'(busy), 32'd0);
      chk("wr_missing", 32'(exp_q.size()), 32'd0);
      chk("nack_count", 32'(nack_seen), 32'(nack_exp));
      chk("reg_addr_hold", 32'(reg_addr), 32'(last_addr));
      chk("reg_data_hold", 32'(reg_data), 32'(last_data));
    end
  endtask

  task automatic set3(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c);
    fb[0] = a; fb[1] = b; fb[2] = c; fb[3] = 8'h00;
  endtask

  initial begin
    clks(3);
    chk("rst_oen", 32'(oen), 32'd0);
    chk("rst_addr", 32'(reg_addr), 32'd0);
    chk("rst_data", 32'(reg_data), 32'd0);
    chk("rst_valid", 32'(wr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_nack", 32'(nack), 32'd0);
    rst_n = 1'b1;
    clks(4);

    set3(8'h34, 8'h1E, 8'h00); run_frame(3, 1'b1);
    set3(8'h34, 8'h08, 8'h15); run_frame(3, 1'b1);
    set3(8'h36, 8'h08, 8'h15); run_frame(3, 1'b1);
    set3(8'h35, 8'h08, 8'h15); run_frame(1, 1'b1);
    set3(8'h34, 8'h0C, 8'h00); run_frame(2, 1'b1);

    i2c_start;
    send_byte(8'h34, 1'b1, 1'b0);
    send_bits(8'hA5, 5);
    scl_m = 1'b0;
    set3(8'h34, 8'h12, 8'h01); run_frame(3, 1'b1);

    i2c_start;
    send_byte(8'h34, 1'b1, 1'b1);
    scl_m = 1'b1; sda_m = 1'b1;
    last_addr = 0; last_data = 0;
    clks(4);
    chk("rst_clears_addr", 32'(reg_addr), 32'd0);
    rst_n = 1'b1;
    clks(4);
    set3(8'h34, 8'hAA, 8'h55); run_frame(3, 1'b1);

    for (int f = 0; f < 30; f++) begin
      int n;
      n = int'($urandom_range(1, 4));
      fb[0] = ($urandom_range(0, 3) != 0) ? 8'h34 : 8'($urandom);
      fb[1] = 8'($urandom);
      fb[2] = 8'($urandom);
      fb[3] = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        i2c_start;
        send_bits(8'($urandom), int'($urandom_range(1, 7)));
      end
      run_frame(n, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/i2c_codec_responder.md
Name: i2c_codec_responder

Overview:
I2C target (responder) that models the audio codec's 3-byte write-only control port: device address, then a register address plus data MSB, then data LSBs.
It sits opposite the I2C initializer, on the same SCL/SDA pair, in simulation and loopback benches.
It acknowledges correctly addressed bytes and presents each completed 7-bit address / 9-bit data register write as a one-cycle strobe.

Parameters:
DEV_ADDR, 7'b0011010, 7-bit target address matched against the first byte (write byte 0x34).
SYNC_STAGES, 2, synchroniser depth on SCL and SDA inputs (minimum 2).

Ports:
i_clk  in  1  system clock; must be at least 8x the SCL frequency.
i_rst_n  in  1  reset.
i_sclk  in  1  I2C SCL from the initiator.
i_sdat  in  1  I2C SDA as seen on the bus (resolved value).
o_sdat_oen  out  1  1 = responder pulls SDA low (ACK). 0 = released.
o_reg_addr  out  7  register address of the last completed write.
o_reg_data  out  9  data of the last completed write.
o_wr_valid  out  1  one-cycle strobe; addr/data valid in the same cycle.
o_busy  out  1  high from START until STOP.
o_nack  out  1  one-cycle strobe when the address byte is rejected.

Behaviour:
- Interface (already decided): one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values: all outputs 0. State is IDLE. Counters and shift register are 0.
- Reset asserted mid-operation: o_sdat_oen drops immediately (asynchronously) and the FSM returns to IDLE.
- Synchronisation:
  - SCL and SDA each pass through SYNC_STAGES flops, plus one delay flop for edge detection.
  - Pin-to-event latency is SYNC_STAGES+1 cycles.
- Bus conditions, evaluated on synchronised signals:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - START and STOP take priority over data events in the same cycle and are honoured from any state.
- START: state goes to SHIFT; bit_cnt=0, byte_cnt=0, o_busy=1, o_sdat_oen=0. A repeated START restarts the frame and discards partial bytes.
- STOP: state goes to IDLE; o_busy=0, o_sdat_oen=0. A frame with fewer than 3 acknowledged bytes produces no o_wr_valid.
- SHIFT:
  - On each SCL rise, shift SDA in MSB-first and increment bit_cnt (3-bit).
  - After the 8th rise, the next SCL fall evaluates the byte.
  - byte_cnt=0: if byte[7:1]==DEV_ADDR and byte[0]==0, go to ACK. Otherwise pulse o_nack and go to IGNORE; SDA stays released.
  - byte_cnt=1: capture addr=byte[7:1] and data[8]=byte[0], then go to ACK.
  - byte_cnt=2: capture data[7:0]=byte, then go to ACK.
- ACK:
  - o_sdat_oen=1 from the cycle after the 8th-bit SCL fall.
  - On the next SCL fall (end of 9th clock), o_sdat_oen=0 in the following cycle and byte_cnt increments.
  - If byte_cnt becomes 3: update o_reg_addr/o_reg_data and pulse o_wr_valid for that cycle, then go to IGNORE. Otherwise go to SHIFT with bit_cnt=0.
- IGNORE: SDA is never driven; the FSM waits only for START or STOP. Bytes beyond the third are not acknowledged.
- SDA changes while SCL is high that are not START/STOP conditions do not occur in legal traffic and are treated as START/STOP as detected.
- o_reg_addr and o_reg_data hold their values between writes.
- Size: 4-state FSM (IDLE, SHIFT, ACK, IGNORE), 3-bit bit_cnt, 2-bit byte_cnt, 8-bit shift register.

Decomposition:
- Shared package i2c_pkg holds:
  - state enum i2c_rsp_state_t {IDLE, SHIFT, ACK, IGNORE};
  - constant CODEC_DEV_ADDR = 7'b0011010;
  - constant I2C_FRAME_BYTES = 3.
- One sub-module, i2c_bus_sync: parameterised synchroniser plus edge/START/STOP detector. Outputs are scl_rise, scl_fall, sda_sync, start_det, stop_det.

Test Plan:
- Bytes 0x34, 0x1E, 0x00 then STOP -> three ACK pulses on o_sdat_oen. One o_wr_valid with o_reg_addr=0x0F, o_reg_data=0x000. o_busy falls after STOP.
- Bytes 0x34, 0x08, 0x15 -> o_reg_addr=0x04, o_reg_data=0x015. o_sdat_oen is high exactly during the 9th SCL period of each byte.
- Address byte 0x36 (and separately 0x35, the read bit) -> o_nack pulses once, o_sdat_oen never asserts, no o_wr_valid.
- 0x34, 0x0C then STOP -> two ACKs, no o_wr_valid, o_reg_addr/o_reg_data keep their previous values.
- Repeated START after 5 bits of byte 1, then full 0x34, 0x12, 0x01 -> single o_wr_valid with addr=0x09, data=0x001.
- i_rst_n pulled low while o_sdat_oen=1 -> o_sdat_oen=0 in the same time step. After release, a new full frame is accepted normally.
- Full WM8731 init sequence from the I2C initializer connected to this block -> one o_wr_valid per command with matching addr/data, and the initializer's o_finished asserts.
